score_display: RTL and testbench

Renders the 5-bit game score produced by the collision score counter on the board's 4-digit multiplexed 7-segment display. It watches the score bus and, on any change, runs a sequential binary-to-BCD conversion (shift-add-3). It then latches the resulting tens/ones digits atomically and time-multiplexes them onto the anode/segment pins. The block sits between the score counter and the top-level display pins.

---
 rtl/score_pkg.sv | 40 ++++
 rtl/score_display_bin2bcd_seq.sv | 77 +++++++
 rtl/score_display.sv | 60 ++++++
 tb/tb_score_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared widths, FSM encoding and 7-segment/anode patterns for score_display
package score_pkg;
    localparam int SCORE_W = 5;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_0   = 4'b1110;
    localparam logic [3:0] AN_1   = 4'b1101;
    localparam logic [3:0] AN_2   = 4'b1011;
    localparam logic [3:0] AN_3   = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// bin2bcd_seq: change-triggered sequential shift-add-3 converter with atomic tens/ones latch
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = score_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         tens,
    output logic [3:0]         ones,
    output logic               busy
);
    localparam int SR_W  = 8 + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] last_q, last_d;
    logic [3:0]         tens_q, tens_d, ones_q, ones_d;
    logic [3:0]         t_adj, o_adj;

    // next state: IDLE watches for a new score, SHIFT runs one add-3/shift per cycle, DONE latches both digits together
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        t_adj   = sr_q[SR_W-1 -: 4] >= 4'd5 ? sr_q[SR_W-1 -: 4] + 4'd3 : sr_q[SR_W-1 -: 4];
        o_adj   = sr_q[SR_W-5 -: 4] >= 4'd5 ? sr_q[SR_W-5 -: 4] + 4'd3 : sr_q[SR_W-5 -: 4];
        case (state_q)
            IDLE: if (score != last_q) begin
                sr_d    = {8'b0, score};
                last_d  = score;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sr_d    = {t_adj[2:0], o_adj, sr_q[SCORE_W-1:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = cnt_q == CNT_W'(SCORE_W - 1) ? DONE : SHIFT;
            end
            DONE: begin
                tens_d  = sr_q[SR_W-1 -: 4];
                ones_d  = sr_q[SR_W-5 -: 4];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;
    assign busy = state_q != IDLE;
endmodule

// File: rtl/score_display.sv
// score_display: converts the score to BCD and multiplexes it onto a 4-digit active-low 7-segment display
module score_display
    import score_pkg::*;
#(
    parameter int SCORE_W     = score_pkg::SCORE_W,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    output logic [3:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               busy
);
    localparam int RW = $clog2(REFRESH_DIV);

    logic [3:0]    tens, ones;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .tens  (tens),
        .ones  (ones),
        .busy  (busy)
    );

    // refresh timing and digit selection; tens is blanked when zero, upper two digits are always blank
    always_comb begin
        ref_d = ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + RW'(1);
        idx_d = ref_q == RW'(REFRESH_DIV - 1) ? idx_q + 2'd1 : idx_q;
        an_d  = idx_q == 2'd0 ? AN_0 : idx_q == 2'd1 ? AN_1 : idx_q == 2'd2 ? AN_2 : AN_3;
        seg_d = idx_q == 2'd0 ? seg_of(ones) :
                idx_q == 2'd1 && tens != 4'd0 ? seg_of(tens) : SEG_BLANK;
    end

    // registered pins so anode and segment change on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_q <= '0;
            idx_q <= '0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            ref_q <= ref_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: scoreboard bench for conversion results, timing and multiplexed display pins
module tb_score_display;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] score = 5'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    logic busy_prev = 1'b0;

    score_display #(.SCORE_W(5), .REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic push(input int s);
        exp_q.push_back({4'(s / 10), 4'(s % 10)});
    endtask

    always @(posedge clk) begin
        logic r;
        r = reset;
        #1;
        if (busy_prev && !busy && !r) begin
            if (exp_q.size() == 0) check("sb_underflow", 1, 0);
            else check("sb_digits", {dut.tens, dut.ones}, exp_q.pop_front());
        end
        busy_prev = busy;
    end

    task automatic wait_idle();
        int k;
        repeat (3) @(posedge clk);
        #1;
        k = 0;
        while (busy && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic chk_display(input int t, input int o);
        logic [3:0] seen = 4'b0;
        logic [6:0] s[4];
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            case (an)
                4'b1110: begin seen[0] = 1'b1; s[0] = seg; end
                4'b1101: begin seen[1] = 1'b1; s[1] = seg; end
                4'b1011: begin seen[2] = 1'b1; s[2] = seg; end
                4'b0111: begin seen[3] = 1'b1; s[3] = seg; end
                default: seen = seen;
            endcase
        end
        check("slots_seen", {28'd0, seen}, 32'hf);
        check("seg_ones", {25'd0, s[0]}, {25'd0, exp_seg(o)});
        check("seg_tens", {25'd0, s[1]}, {25'd0, t == 0 ? 7'b1111111 : exp_seg(t)});
        check("seg_d2", {25'd0, s[2]}, 32'h7f);
        check("seg_d3", {25'd0, s[3]}, 32'h7f);
        check("dp", {31'd0, dp}, 1);
    endtask

    task automatic show(input int v);
        @(negedge clk);
        score = 5'(v);
        push(v);
        wait_idle();
        chk_display(v / 10, v % 10);
    endtask

    initial begin
        int rises;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", {28'd0, an}, 32'hf);
        check("rst_seg", {25'd0, seg}, 32'h7f);
        check("rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_an", {28'd0, an}, 32'he);
        check("post_rst_seg", {25'd0, seg}, 32'h40);
        rises = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (busy) rises++;
        end
        check("idle_no_busy", rises, 0);
        chk_display(0, 0);

        @(negedge clk);
        score = 5'd27;
        push(27);
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check("busy_27", {31'd0, busy}, k < 6 ? 1 : 0);
            if (k == 5) check("early_27", {dut.tens, dut.ones}, 8'h00);
            if (k == 6) check("latch_27", {dut.tens, dut.ones}, 8'h27);
        end
        chk_display(2, 7);

        show(5);
        show(31);
        show(10);

        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            if (k == 0) begin score = 5'd12; push(12); end
            if (k == 2) begin score = 5'd19; push(19); end
            @(posedge clk);
            #1;
            if (k == 6) begin
                check("mid_first", {dut.tens, dut.ones}, 8'h12);
                check("mid_busy6", {31'd0, busy}, 0);
            end
            if (k == 7) check("mid_restart", {31'd0, busy}, 1);
            if (k == 12) check("mid_hold", {dut.tens, dut.ones}, 8'h12);
            if (k == 13) begin
                check("mid_final", {dut.tens, dut.ones}, 8'h19);
                check("mid_busy13", {31'd0, busy}, 0);
            end
        end
        chk_display(1, 9);

        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k == 0) score = 5'd20;
            if (k == 3) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_digits", {dut.tens, dut.ones}, 8'h00);
        check("abort_an", {28'd0, an}, 32'hf);
        check("abort_seg", {25'd0, seg}, 32'h7f);
        @(negedge clk);
        reset = 1'b0;
        push(20);
        for (int j = 0; j <= 6; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) check("restart_busy", {31'd0, busy}, 1);
            if (j == 5) check("restart_early", {dut.tens, dut.ones}, 8'h00);
            if (j == 6) check("restart_20", {dut.tens, dut.ones}, 8'h20);
        end
        chk_display(2, 0);

        show(9);
        show(16);
        show(0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
